// File: rtl/sub32_lookahead_pipe.sv
// sub32_lookahead_pipe: four-stage pipelined 32-bit modular subtractor.
// Computes in_a - in_b as in_a + ~in_b + 1, one 8-bit carry-lookahead slice
// per stage, with the inter-slice carry registered. Valid/ready on both ends.
// Optional build macro ADDSUB_MODE_EN adds an in_sub port that selects
// add (in_sub=0) or subtract (in_sub=1) per operation.
module sub32_lookahead_pipe #(
  parameter int unsigned STAGES    = 4,
  parameter int unsigned ZERO_FLAG = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
`ifdef ADDSUB_MODE_EN
  input  logic        in_sub,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_diff,
  output logic        out_c,
  output logic        out_zero
);

  if (STAGES != 4) begin : g_stages_check
    $error("sub32_lookahead_pipe: STAGES must be 4");
  end

  // 8-bit carry-lookahead slice: returns {carry_out, sum[7:0]}.
  // Internal carries are sum-of-products; carry_out uses group G/P.
  function automatic logic [8:0] cla8(input logic [7:0] a,
                                      input logic [7:0] bx,
                                      input logic       cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       t;
    logic       grp_g;
    logic       grp_p;
    g = a & bx;
    p = a | bx;
    c = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 7; i++) begin
      t = cin;
      for (int unsigned j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    grp_p = &p;
    grp_g = 1'b0;
    for (int unsigned j = 0; j < 8; j++) begin
      t = g[j];
      for (int unsigned k = j + 1; k < 8; k++) t = t & p[k];
      grp_g = grp_g | t;
    end
    c[8] = grp_g | (grp_p & cin);
    return {c[8], a ^ bx ^ c[7:0]};
  endfunction

  // Operation select: subtract inverts B and injects carry-in 1.
  logic        sub_in;
`ifdef ADDSUB_MODE_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b1;
`endif

  logic [31:0] bx_in;
  assign bx_in = sub_in ? ~in_b : in_b;

  // Stage k holds result bytes 0..k, operand bytes k+1..3 and carry of slice k.
  logic        v0, v1, v2, v3;
  logic [31:8]  a0, bx0;
  logic [31:16] a1, bx1;
  logic [31:24] a2, bx2;
  logic [7:0]  r0;
  logic [15:0] r1;
  logic [23:0] r2;
  logic [31:0] r3;
  logic        c0, c1, c2;
  logic        sub0, sub1, sub2;
  logic        oc3, z3;

  logic [8:0]  sl0, sl1, sl2, sl3;
  assign sl0 = cla8(in_a[7:0], bx_in[7:0], sub_in);
  assign sl1 = cla8(a0[15:8],  bx0[15:8],  c0);
  assign sl2 = cla8(a1[23:16], bx1[23:16], c1);
  assign sl3 = cla8(a2[31:24], bx2[31:24], c2);

  // Load chain: a stage advances when empty or when its successor advances.
  logic ld0, ld1, ld2, ld3, acc;
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign ld0      = !v0 || ld1;
  assign in_ready = reset_n && ld0;
  assign acc      = in_valid && in_ready;

  // Stage 0: capture operands and byte 0 result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v0   <= 1'b0;
      a0   <= '0;
      bx0  <= '0;
      r0   <= '0;
      c0   <= 1'b0;
      sub0 <= 1'b0;
    end else if (ld0) begin
      v0 <= acc;
      if (acc) begin
        a0   <= in_a[31:8];
        bx0  <= bx_in[31:8];
        r0   <= sl0[7:0];
        c0   <= sl0[8];
        sub0 <= sub_in;
      end
    end
  end

  // Stage 1: byte 1 from registered carry of stage 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      bx1  <= '0;
      r1   <= '0;
      c1   <= 1'b0;
      sub1 <= 1'b0;
    end else if (ld1) begin
      v1 <= v0;
      if (v0) begin
        a1   <= a0[31:16];
        bx1  <= bx0[31:16];
        r1   <= {sl1[7:0], r0};
        c1   <= sl1[8];
        sub1 <= sub0;
      end
    end
  end

  // Stage 2: byte 2 from registered carry of stage 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      a2   <= '0;
      bx2  <= '0;
      r2   <= '0;
      c2   <= 1'b0;
      sub2 <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        a2   <= a1[31:24];
        bx2  <= bx1[31:24];
        r2   <= {sl2[7:0], r1};
        c2   <= sl2[8];
        sub2 <= sub1;
      end
    end
  end

  // Stage 3: final byte, borrow/carry and zero flag, all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v3  <= 1'b0;
      r3  <= '0;
      oc3 <= 1'b0;
      z3  <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        r3  <= {sl3[7:0], r2};
        oc3 <= sub2 ? !sl3[8] : sl3[8];
        z3  <= (ZERO_FLAG != 0) && ({sl3[7:0], r2} == '0);
      end
    end
  end

  assign out_valid = v3;
  assign out_diff  = r3;
  assign out_c     = oc3;
  assign out_zero  = z3;

endmodule

// File: tb/tb_sub32_lookahead_pipe.sv
// Self-checking bench for sub32_lookahead_pipe: directed test-plan cases,
// back-pressure, mid-stream reset and a randomized stream scored against a
// plain-arithmetic reference queue.
module tb_sub32_lookahead_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
`ifdef ADDSUB_MODE_EN
  logic        in_sub = 1'b1;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_diff;
  logic        out_c;
  logic        out_zero;

  always #5 clock = ~clock;

  sub32_lookahead_pipe #(.STAGES(4), .ZERO_FLAG(1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef ADDSUB_MODE_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_c     (out_c),
    .out_zero  (out_zero)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        z;
    int unsigned t;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_del = 0;
  int unsigned cyc = 0;
  bit          last_acc, last_del;
  bit          lat_chk = 1'b0;
  bit          held = 1'b0;
  exp_t        hd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on whole words.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit sub);
    exp_t        e;
    logic [32:0] t;
    e = '0;
    if (sub) begin
      e.d = a - b;
      e.c = (a < b);
    end else begin
      t   = {1'b0, a} + {1'b0, b};
      e.d = t[31:0];
      e.c = t[32];
    end
    e.z = (e.d == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive at negedge, sample handshakes 1ns later.
  task automatic step(input bit rn, input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input bit sub, input bit ordy);
    exp_t e;
    bit   s;
    @(negedge clock);
    reset_n   = rn;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    s = 1'b1;
`ifdef ADDSUB_MODE_EN
    s      = sub;
    in_sub = sub;
`endif
    #1;
    cyc++;
    last_acc = in_valid && in_ready;
    last_del = out_valid && out_ready;
    if (!rn) begin
      check("in_ready_in_reset", in_ready, 0);
      held = 1'b0;
      q.delete();
      return;
    end
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_diff", out_diff, hd.d);
      check("hold_c", out_c, hd.c);
      check("hold_zero", out_zero, hd.z);
    end
    held = out_valid && !out_ready;
    hd   = '{d: out_diff, c: out_c, z: out_zero, t: 0};
    if (last_del) begin
      n_del++;
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("diff", out_diff, e.d);
        check("c", out_c, e.c);
        check("zero", out_zero, e.z);
        if (lat_chk) check("latency", cyc - e.t, 4);
      end
    end
    if (last_acc) begin
      e   = model(a, b, s);
      e.t = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && q.size() > 0; i++) step(1, 0, '0, '0, 1, 1);
    check("drain_empty", q.size(), 0);
  endtask

  // Single operation into an empty pipe; result must appear exactly 4 cycles later.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input bit sub,
                         input logic [31:0] xd, input bit xc, input bit xz);
    step(1, 1, a, b, sub, 1);
    check("one_accept", last_acc, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0, '0, 1, 1);
      check("one_early_valid", out_valid, 0);
    end
    step(1, 0, '0, '0, 1, 1);
    check("one_valid", out_valid, 1);
    check("one_diff", out_diff, xd);
    check("one_c", out_c, xc);
    check("one_zero", out_zero, xz);
  endtask

  logic [31:0] da[6] = '{32'h0000_0005, 32'h0000_0000, 32'h0001_0000,
                         32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] db[6] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                         32'h1234_5678, 32'h0000_0000, 32'h8000_0001};
  logic [31:0] ba[6];
  logic [31:0] bb[6];

  initial begin
    int unsigned idx;
    int unsigned d0;
    logic [31:0] ra, rb;

    // Reset state; empty pipe is ready even with out_ready low.
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0);
    step(1, 0, '0, '0, 1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_zero", out_zero, 0);
    check("empty_in_ready", in_ready, 1);

    // Test-plan arithmetic cases.
    lat_chk = 1'b1;
    run_one(32'h5, 32'h3, 1, 32'h2, 0, 0);
    run_one(32'h0, 32'h1, 1, 32'hFFFF_FFFF, 1, 0);
    run_one(32'h0001_0000, 32'h1, 1, 32'h0000_FFFF, 0, 0);
    run_one(32'h1234_5678, 32'h1234_5678, 1, 32'h0, 0, 1);

    // Back-to-back directed stream, full throughput.
    for (int i = 0; i < 6; i++) step(1, 1, da[i], db[i], 1, 1);
    drain(20);

    // Back-pressure: six offers with out_ready low, only four fit.
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, ba[idx], bb[idx], 1, 0);
      if (last_acc) idx++;
      else check("full_in_ready", in_ready, 0);
    end
    check("bp_accepted", idx, 4);
    d0 = n_del;
    step(1, 1, ba[idx], bb[idx], 1, 1);
    check("no_bubble", {last_acc, last_del}, 2'b11);
    if (last_acc) idx++;
    for (int i = 0; i < 3; i++) begin
      if (idx < 6) begin
        step(1, 1, ba[idx], bb[idx], 1, 1);
        if (last_acc) idx++;
      end else begin
        step(1, 0, '0, '0, 1, 1);
      end
    end
    check("bp_drain_rate", n_del - d0, 4);
    check("bp_rest_accepted", idx, 6);
    drain(20);

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, $urandom, 1, 0);
    step(0, 0, '0, '0, 1, 0);
    step(1, 0, '0, '0, 1, 1);
    check("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) step(1, 0, '0, '0, 1, 1);
    lat_chk = 1'b1;
    run_one(32'hDEAD_BEEF, 32'h0000_BEEF, 1, 32'hDEAD_0000, 0, 0);

`ifdef ADDSUB_MODE_EN
    run_one(32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 1);
    for (int i = 0; i < 40; i++) step(1, 1, pick(), pick(), i[0], 1);
    drain(20);
`endif

    // Randomized stream with random stalls.
    lat_chk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick();
      step(1, $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
